// File: rtl/button_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter_if
// Description : Press inputs, event valid/ready handshake and debug outputs
//               of the button event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_event_arbiter_if #(
  parameter int N_BTN  = 4,
  parameter int CODE_W = 2,
  parameter int DROP_W = 8
);
  logic [N_BTN-1:0]  press;
  logic              enable;
  logic              ev_valid;
  logic [CODE_W-1:0] ev_code;
  logic              ev_ready;
  logic [N_BTN-1:0]  pending;
  logic [DROP_W-1:0] drop_count;

  // Producer of presses and consumer of events.
  modport master (
    output press, enable, ev_ready,
    input  ev_valid, ev_code, pending, drop_count
  );

  // The arbiter itself.
  modport slave (
    input  press, enable, ev_ready,
    output ev_valid, ev_code, pending, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : One-deep pending latch per button, round-robin grant into a
//               valid/ready output register, saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
  parameter int N_BTN  = 4,
  parameter int CODE_W = 2,
  parameter int DROP_W = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  button_event_arbiter_if.slave bus
);

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_HOLD = 1'b1;

  // Enough bits to count every button dropping in the same cycle.
  localparam int c_CNT_W = $clog2(N_BTN + 1);
  localparam int c_SUM_W = DROP_W + c_CNT_W;
  localparam logic [c_SUM_W-1:0] c_DROP_MAX = {{c_CNT_W{1'b0}}, {DROP_W{1'b1}}};
  localparam logic [CODE_W-1:0]  c_LAST     = CODE_W'(N_BTN - 1);

  logic [0:0]         r_state;
  logic [N_BTN-1:0]   r_pending;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  r_ptr;
  logic [DROP_W-1:0]  r_drop;

  logic               w_found;
  logic [CODE_W-1:0]  w_gidx;
  logic               w_do_grant;
  logic [N_BTN-1:0]   w_set;
  logic [N_BTN-1:0]   w_clear;
  logic [N_BTN-1:0]   w_drop;
  logic [N_BTN-1:0]   w_pend_nxt;
  logic [c_CNT_W-1:0] w_ndrop;
  logic [c_SUM_W-1:0] w_drop_sum;
  logic [DROP_W-1:0]  w_drop_nxt;
  logic [CODE_W-1:0]  w_ptr_nxt;

  // Round-robin search of the registered latches starting at the pointer.
  always_comb begin : p_search
    int w_idx;
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_BTN) w_idx = w_idx - N_BTN;
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = CODE_W'(w_idx);
      end
    end
  end

  // A grant happens only when the output register is free or being consumed.
  assign w_do_grant = w_found && ((r_state == c_S_IDLE) || bus.ev_ready);
  assign w_clear    = w_do_grant ? (N_BTN'(1) << w_gidx) : '0;
  assign w_set      = bus.press & {N_BTN{bus.enable}};
  // A press onto a pending latch survives only if that latch is being granted.
  assign w_drop     = w_set & r_pending & ~w_clear;
  assign w_pend_nxt = (r_pending & ~w_clear) | w_set;
  assign w_ptr_nxt  = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

  // Count simultaneous drops and add them with saturation.
  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_ndrop = w_ndrop + c_CNT_W'(w_drop[i]);
    end
    w_drop_sum = c_SUM_W'(r_drop) + c_SUM_W'(w_ndrop);
    w_drop_nxt = (w_drop_sum > c_DROP_MAX) ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
  end

  // Latches, drop counter and the IDLE/HOLD output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_S_IDLE;
      r_pending <= '0;
      r_code    <= '0;
      r_ptr     <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_drop    <= w_drop_nxt;
      if (w_do_grant) begin
        r_code <= w_gidx;
        r_ptr  <= w_ptr_nxt;
      end
      case (r_state)
        c_S_IDLE: if (w_do_grant) r_state <= c_S_HOLD;
        c_S_HOLD: if (bus.ev_ready && !w_do_grant) r_state <= c_S_IDLE;
        default:  r_state <= c_S_IDLE;
      endcase
    end
  end

  assign bus.ev_valid   = (r_state == c_S_HOLD);
  assign bus.ev_code    = r_code;
  assign bus.pending    = r_pending;
  assign bus.drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_arbiter
// Description : Directed vector table, corner-case sequences and randomized
//               stimulus against a behavioural model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  button_event_arbiter_if #(.N_BTN(N), .CODE_W(2), .DROP_W(8)) bif ();
  button_event_arbiter_if #(.N_BTN(N), .CODE_W(2), .DROP_W(2)) bif2 ();

  // The narrow-counter instance sees exactly the same stimulus.
  assign bif2.press    = bif.press;
  assign bif2.enable   = bif.enable;
  assign bif2.ev_ready = bif.ev_ready;

  button_event_arbiter #(.N_BTN(N), .CODE_W(2), .DROP_W(8)) dut (
    .clk (clk), .rst (rst), .bus (bif)
  );
  button_event_arbiter #(.N_BTN(N), .CODE_W(2), .DROP_W(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bif2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of pending buttons, a pointer, one held event.
  bit m_pend[N];
  int m_ptr, m_code, m_drop, m_drop2;
  bit m_valid;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_ptr = 0; m_code = 0; m_drop = 0; m_drop2 = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic [N-1:0] press, input bit en, input bit rdy);
    int g;
    int drops;
    g = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) begin
        m_valid = 1; m_code = g; m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    drops = 0;
    for (int i = 0; i < N; i++) begin
      if (press[i] && en) begin
        if (m_pend[i] && g != i) drops++;
        m_pend[i] = 1;
      end else if (g == i) begin
        m_pend[i] = 0;
      end
    end
    m_drop  = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_drop2 = (m_drop2 + drops > 3) ? 3 : m_drop2 + drops;
  endtask

  function automatic int model_pend_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
    return v;
  endfunction

  // Called on a falling edge: drive, clock once, return on the next falling edge.
  task automatic apply(input logic [N-1:0] p, input bit en, input bit rdy);
    bif.press = p; bif.enable = en; bif.ev_ready = rdy;
    @(posedge clk);
    model_step(bif.press, bif.enable, bif.ev_ready);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bif.press = '0; bif.enable = 1'b1; bif.ev_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] press;
    bit         en;
    bit         rdy;
    bit         v;
    int         c;
    logic [3:0] p;
    int         d;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bif.press = '0; bif.enable = 1'b1; bif.ev_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state.
    do_reset();
    check("reset ev_valid", int'(bif.ev_valid), 0);
    check("reset ev_code", int'(bif.ev_code), 0);
    check("reset pending", int'(bif.pending), 0);
    check("reset drop", int'(bif.drop_count), 0);

    // ---- directed vectors: {rst, press, en, rdy, exp valid, code, pending, drops}
    // single press and latency
    tbl.push_back('{1, 4'b0100, 1, 0, 0, 0, 4'b0100, 0});
    tbl.push_back('{0, 4'b0000, 1, 0, 1, 2, 4'b0000, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 2, 4'b0000, 0});
    // round-robin over all buttons from ptr 0
    tbl.push_back('{1, 4'b1111, 1, 1, 0, 0, 4'b1111, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 0, 4'b1110, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 1, 4'b1100, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 2, 4'b1000, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 3, 4'b0000, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 3, 4'b0000, 0});
    // 1001 from ptr 0 gives 0 then 3
    tbl.push_back('{0, 4'b1001, 1, 1, 0, 3, 4'b1001, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 0, 4'b1000, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 3, 4'b0000, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 3, 4'b0000, 0});
    // move ptr to 1, then 1001 gives 3 then 0
    tbl.push_back('{0, 4'b0001, 1, 1, 0, 3, 4'b0001, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 0, 4'b0000, 0});
    tbl.push_back('{0, 4'b1001, 1, 1, 0, 0, 4'b1001, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 3, 4'b0001, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 0, 4'b0000, 0});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 0, 4'b0000, 0});
    // backpressure: event 1 held, pending[1] set again, three drops
    tbl.push_back('{0, 4'b0010, 1, 0, 0, 0, 4'b0010, 0});
    tbl.push_back('{0, 4'b0000, 1, 0, 1, 1, 4'b0000, 0});
    tbl.push_back('{0, 4'b0010, 1, 0, 1, 1, 4'b0010, 0});
    tbl.push_back('{0, 4'b0010, 1, 0, 1, 1, 4'b0010, 1});
    tbl.push_back('{0, 4'b0000, 1, 0, 1, 1, 4'b0010, 1});
    tbl.push_back('{0, 4'b0010, 1, 0, 1, 1, 4'b0010, 2});
    tbl.push_back('{0, 4'b0010, 1, 0, 1, 1, 4'b0010, 3});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 1, 4'b0000, 3});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 1, 4'b0000, 3});
    // set wins over clear on the granted button
    tbl.push_back('{0, 4'b0100, 1, 1, 0, 1, 4'b0100, 3});
    tbl.push_back('{0, 4'b0100, 1, 1, 1, 2, 4'b0100, 3});
    tbl.push_back('{0, 4'b0000, 1, 1, 1, 2, 4'b0000, 3});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 2, 4'b0000, 3});
    // enable low ignores presses without counting them
    tbl.push_back('{0, 4'b1111, 0, 1, 0, 2, 4'b0000, 3});
    tbl.push_back('{0, 4'b1111, 0, 1, 0, 2, 4'b0000, 3});
    tbl.push_back('{0, 4'b0000, 1, 1, 0, 2, 4'b0000, 3});

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst) do_reset();
      apply(tbl[r].press, tbl[r].en, tbl[r].rdy);
      check($sformatf("vec%0d ev_valid", r), int'(bif.ev_valid), int'(tbl[r].v));
      check($sformatf("vec%0d ev_code", r), int'(bif.ev_code), tbl[r].c);
      check($sformatf("vec%0d pending", r), int'(bif.pending), int'(tbl[r].p));
      check($sformatf("vec%0d drop", r), int'(bif.drop_count), tbl[r].d);
      check($sformatf("vec%0d drop_w2", r), int'(bif2.drop_count), (tbl[r].d > 3) ? 3 : tbl[r].d);
    end

    // ---- simultaneous drops and saturation of the 2-bit counter
    do_reset();
    apply(4'b1111, 1, 0);   // all pending
    apply(4'b0000, 1, 0);   // 0 granted and held, 1..3 pending
    apply(4'b1111, 1, 0);   // 0 re-latched, 1..3 dropped
    check("multi drop", int'(bif.drop_count), 3);
    apply(4'b1111, 1, 0);   // four more drops
    check("sum drop", int'(bif.drop_count), 7);
    check("sat drop_w2", int'(bif2.drop_count), 3);
    check("sat pending", int'(bif.pending), 4'b1111);

    // ---- asynchronous reset while an event is held and 1010 is pending
    do_reset();
    apply(4'b1010, 1, 0);
    apply(4'b0000, 1, 0);   // grant 1, held
    apply(4'b0010, 1, 0);   // pending back to 1010
    check("pre-rst ev_valid", int'(bif.ev_valid), 1);
    check("pre-rst pending", int'(bif.pending), 4'b1010);
    #2 rst = 1'b1;
    #1;
    check("async ev_valid", int'(bif.ev_valid), 0);
    check("async ev_code", int'(bif.ev_code), 0);
    check("async pending", int'(bif.pending), 0);
    check("async drop", int'(bif.drop_count), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'b0000, 1, 1);
      check($sformatf("post-rst ev_valid %0d", i), int'(bif.ev_valid), 0);
    end

    // ---- randomized stimulus against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] p;
      for (int b = 0; b < N; b++) p[b] = ($urandom_range(0, 3) == 0);
      apply(p, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6);
      check("rand ev_valid", int'(bif.ev_valid), int'(m_valid));
      if (m_valid) check("rand ev_code", int'(bif.ev_code), m_code);
      check("rand pending", int'(bif.pending), model_pend_vec());
      check("rand drop", int'(bif.drop_count), m_drop);
      check("rand drop_w2", int'(bif2.drop_count), m_drop2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle press pulses from the per-button synchronizer/edge-detector instances and serializes them into one event stream for the game/control FSM. Each button has a one-deep pending latch; a round-robin arbiter grants one pending button at a time into an output register guarded by a valid/ready handshake. Presses that arrive while a button's event is still pending are dropped and counted.

## Interface
- N_BTN, 4, number of buttons (2..16)
- CODE_W, 2, event code width, equal to ceil(log2(N_BTN))
- DROP_W, 8, drop counter width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- press  in  N_BTN  one-cycle press pulses, already synchronous to clk
- enable  in  1  1 = accept new presses; 0 = ignore new presses
- ev_valid  out  1  output event available
- ev_code  out  CODE_W  index of the button for the current event
- ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
- pending  out  N_BTN  registered pending latches, for debug
- drop_count  out  DROP_W  saturating count of dropped presses

## Operation
- Reset values: pending=0, ev_valid=0, ev_code=0, drop_count=0, round-robin pointer ptr=0, state IDLE. Reset is asynchronous; a reset asserted mid-handshake discards the held event and all pending presses.
- Pending latch, per button i, each cycle:
  - set if press[i] & enable;
  - cleared if button i is granted this cycle;
  - if set and clear occur in the same cycle, set wins and the latch stays 1, with no drop;
  - if press[i] & enable while pending[i]=1 and i is not granted this cycle, the press is dropped and drop_count increments.
- Drop accounting:
  - several simultaneous drops in one cycle add their full count;
  - drop_count saturates at 2^DROP_W-1 and never wraps.
- Effect of enable:
  - enable=0 ignores presses; ignored presses are not counted as drops;
  - existing pending latches still drain while enable=0.
- Arbitration:
  - operates on registered pending only;
  - searches indices ptr, ptr+1, …, wrapping modulo N_BTN;
  - the first set bit is granted;
  - after a grant of index g, ptr becomes (g+1) mod N_BTN, with N_BTN-1 wrapping to 0.
- FSM:
  - IDLE: ev_valid=0. If any pending bit is set, grant it, load ev_code, and go to HOLD.
  - HOLD: ev_valid=1, and ev_code is held stable until the handshake. When ev_valid & ev_ready:
    - if any pending bit is set, grant and load the next event in the same cycle and stay in HOLD (back-to-back events, no bubble);
    - otherwise go to IDLE.
  - HOLD without ev_ready: no grant, and pending latches keep accumulating.
- In IDLE, ev_code keeps its last value and is don't-care for the consumer.

## Timing
- Press-to-event latency with an idle arbiter and empty latches: press high in cycle t → pending set in t+1 → ev_valid=1 with ev_code in t+2.
- Throughput: one event per cycle while ev_ready is held 1 and latches are non-empty.
- ev_valid never drops without a handshake, except on rst.
- All outputs are registered; there is no combinational path from press or ev_ready to any output.

## Test plan
- Reset, then a single press: press=4'b0100 for one cycle at t → ev_valid=1, ev_code=2 at t+2; ev_ready=1 → ev_valid=0 the next cycle; drop_count=0.
- Round-robin fairness and wrap: press=4'b1111 in one cycle with ev_ready held 1 → ev_code sequence 0,1,2,3 on consecutive cycles. Then press=4'b1001 → codes 0,3. Then, with ptr=1, press=4'b1001 → codes 3,0.
- Backpressure and drops:
  - ev_ready=0 and pending[1] already set;
  - press[1] pulses on 3 separate cycles → drop_count=3, pending=4'b0010;
  - ev_ready=1 → exactly one event with code 1 is delivered.
- Set-wins-over-clear: press[2] in the same cycle that button 2 is granted → pending[2] stays 1, a second code 2 follows, and drop_count is unchanged.
- Enable and saturation:
  - enable=0 with pulses on all buttons → no events, drop_count unchanged;
  - with DROP_W=2, force 5 drops → drop_count=3.
- Async reset mid-operation: assert rst while ev_valid=1 and pending=4'b1010, between clock edges → outputs go to 0 immediately, and no events follow after release.
